// File: rtl/mem_access_unit.sv
// Load/store sequencer between the datapath and a word-wide synchronous memory.
// Handles LW/LH/LB and SW/SH/SB, using read-modify-write for sub-word stores.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mdr_out,
    output logic [7:0]  byte_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

    state_e      state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        start_err;
    logic [31:0] load_word;
    logic [31:0] store_word;

    // Decode of the live request, only meaningful while idle.
    always_comb begin
        start_err = 1'b0;
        unique case (op[1:0])
            2'b00:   start_err = (addr[1:0] != 2'b00);
            2'b01:   start_err = addr[0];
            2'b10:   start_err = 1'b0;
            default: start_err = 1'b1;
        endcase
    end

    always_comb begin
        load_word = 32'h0;
        unique case (op_q[1:0])
            2'b00:   load_word = mem_rdata;
            2'b01:   load_word = addr_q[1] ? {16'h0, mem_rdata[31:16]}
                                           : {16'h0, mem_rdata[15:0]};
            2'b10:   load_word = {24'h0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]};
            default: load_word = 32'h0;
        endcase
    end

    // Sub-word stores merge the new lane into the word fetched during WAIT.
    always_comb begin
        store_word = mem_rdata;
        unique case (op_q[1:0])
            2'b00:   store_word = wdata_q;
            2'b01:   begin
                if (addr_q[1]) begin
                    store_word[31:16] = wdata_q[15:0];
                end else begin
                    store_word[15:0] = wdata_q[15:0];
                end
            end
            2'b10:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: store_word = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            mdr_out   <= 32'h0;
            mem_wr    <= 1'b0;
            mem_wdata <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wr    <= 1'b0;
            mem_wdata <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (start_err) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else if (op == 3'b100) begin
                            state_q   <= StWrite;
                            mem_wr    <= 1'b1;
                            mem_wdata <= wdata;
                            busy      <= 1'b1;
                        end else begin
                            state_q <= StRead;
                            busy    <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (op_q[2]) begin
                        state_q   <= StWrite;
                        mem_wr    <= 1'b1;
                        mem_wdata <= store_word;
                    end else begin
                        state_q <= StDone;
                        mdr_out <= load_word;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StWrite: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = {addr_q[31:2], 2'b00};
    assign byte_out = mdr_out[7:0];

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a one-cycle-latency memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mdr_out;
    logic [7:0]  byte_out;
    logic        busy;
    logic        done;
    logic        err;

    mem_access_unit u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mdr_out   (mdr_out),
        .byte_out  (byte_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:2]];
    end

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] mdr;
        logic        wr;
        int          wr_lat;
        logic [31:0] wr_data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdr_model = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] word,
                                   input logic [31:0] mdr_prev);
        exp_t        e;
        logic [31:0] mask;
        int          sh;
        e.err = (o[1:0] == 2'b11) || (o[1:0] == 2'b00 && a[1:0] != 2'b00) ||
                (o[1:0] == 2'b01 && a[0]);
        e.mdr = mdr_prev;
        e.wr = 1'b0;
        e.wr_lat = 0;
        e.wr_data = 32'h0;
        if (e.err) begin
            e.lat = 1;
        end else if (!o[2]) begin
            e.lat = 3;
            if (o[1:0] == 2'b00) e.mdr = word;
            else if (o[1:0] == 2'b01) e.mdr = (word >> (a[1] ? 16 : 0)) & 32'hFFFF;
            else e.mdr = (word >> (int'(a[1:0]) * 8)) & 32'hFF;
        end else if (o[1:0] == 2'b00) begin
            e.lat = 2;
            e.wr = 1'b1;
            e.wr_lat = 1;
            e.wr_data = wd;
        end else begin
            e.lat = 4;
            e.wr = 1'b1;
            e.wr_lat = 3;
            if (o[1:0] == 2'b01) begin
                sh = a[1] ? 16 : 0;
                mask = 32'hFFFF << sh;
                e.wr_data = (word & ~mask) | ((wd & 32'hFFFF) << sh);
            end else begin
                sh = int'(a[1:0]) * 8;
                mask = 32'hFF << sh;
                e.wr_data = (word & ~mask) | ((wd & 32'hFF) << sh);
            end
        end
        return e;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t        e;
        int          cyc;
        int          wr_cnt;
        int          wr_cyc;
        logic [31:0] wr_dat;
        int          busy_bad;
        int          wd_bad;
        logic        got_done;
        @(negedge clk);
        start = 1'b1;
        op = o;
        addr = a;
        wdata = wd;
        sb_q.push_back(model(o, a, wd, mem[a[11:2]], mdr_model));
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom);
        addr = $urandom;
        wdata = $urandom;
        cyc = 0;
        wr_cnt = 0;
        wr_cyc = -1;
        wr_dat = 32'h0;
        busy_bad = 0;
        wd_bad = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (mem_wr) begin
                wr_cnt++;
                wr_cyc = cyc;
                wr_dat = mem_wdata;
            end else if (mem_wdata != 32'h0) begin
                wd_bad++;
            end
            if (done) got_done = 1'b1;
            else if (!busy) busy_bad++;
        end
        e = sb_q.pop_front();
        chk({tag, ".done"}, 32'(got_done), 32'd1);
        chk({tag, ".lat"}, cyc, e.lat);
        chk({tag, ".err"}, 32'(err), 32'(e.err));
        chk({tag, ".mdr"}, mdr_out, e.mdr);
        chk({tag, ".byte"}, 32'(byte_out), 32'(e.mdr[7:0]));
        chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".nwr"}, wr_cnt, e.wr ? 1 : 0);
        if (e.wr) begin
            chk({tag, ".wrcyc"}, wr_cyc, e.wr_lat);
            chk({tag, ".wdata"}, wr_dat, e.wr_data);
        end
        chk({tag, ".busy_run"}, busy_bad, 0);
        chk({tag, ".wd_idle"}, wd_bad, 0);
        mdr_model = e.mdr;
    endtask

    initial begin
        int          wr_cnt;
        logic [31:0] saved;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h200 >> 2] = 32'h11223344;
        mem[32'h400 >> 2] = 32'h11223344;

        repeat (2) @(negedge clk);
        chk("rst.mdr", mdr_out, 32'h0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.wdata", mem_wdata, 32'h0);
        chk("rst.ctl", {28'h0, mem_wr, busy, done, err}, 32'h0);
        start = 1'b1;
        op = 3'b000;
        addr = 32'h100;
        @(negedge clk);
        chk("rst.start", {28'h0, mem_wr, busy, done, err}, 32'h0);
        start = 1'b0;
        reset = 1'b0;

        do_op("lw", 3'b000, 32'h100, 32'h0);
        mem[32'h100 >> 2] = 32'h80112233;
        do_op("lb3", 3'b010, 32'h103, 32'h0);
        do_op("lb1", 3'b010, 32'h101, 32'h0);
        do_op("lh2", 3'b001, 32'h102, 32'h0);
        do_op("sb", 3'b110, 32'h201, 32'h000000AA);
        do_op("lw_sb", 3'b000, 32'h200, 32'h0);
        mem[32'h200 >> 2] = 32'h11223344;
        do_op("sh", 3'b101, 32'h202, 32'h0000BEEF);
        do_op("sw", 3'b100, 32'h300, 32'h12345678);
        do_op("lw_sw", 3'b000, 32'h300, 32'h0);
        do_op("e_lw", 3'b000, 32'h101, 32'h0);
        do_op("e_op3", 3'b011, 32'h100, 32'h0);
        do_op("e_op7", 3'b111, 32'h100, 32'h0);
        do_op("e_sh", 3'b101, 32'h203, 32'h5555);
        do_op("e_sw", 3'b100, 32'h302, 32'h5555);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom);
            do_op("rnd", ro, {20'h0, 12'($urandom)}, $urandom);
        end

        // Abort an SB while it waits on the read word.
        do_op("lw_pre", 3'b000, 32'h100, 32'h0);
        saved = mem[32'h400 >> 2];
        wr_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        op = 3'b110;
        addr = 32'h401;
        wdata = 32'hAA;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        if (mem_wr) wr_cnt++;
        chk("rstw.busy", 32'(busy), 32'd0);
        chk("rstw.done", 32'(done), 32'd0);
        chk("rstw.mdr", mdr_out, 32'h0);
        chk("rstw.addr", mem_addr, 32'h0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_wr) wr_cnt++;
        end
        chk("rstw.nwr", wr_cnt, 0);
        chk("rstw.mem", mem[32'h400 >> 2], saved);
        chk("rstw.mdr2", mdr_out, 32'h0);
        mdr_model = 32'h0;
        do_op("post", 3'b010, 32'h402, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
